// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
// Holds the FSM state encoding, the master index constants and the default RAM latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int M_CPU = 0;
  localparam int M_LDR = 1;

  localparam int RAM_LAT_DEFAULT = 1;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of both master request/response ports and the RAM-side bus.
// The arbiter uses the slave view; the environment drives the master view.
interface mem_arb_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          m0_req, m0_we, m0_gnt, m0_done;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;

  logic          m1_req, m1_we, m1_gnt, m1_done;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;

  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_rdata,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_rdata,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin winner select with a last-grant pointer.
// On a tie the master not served last wins; after reset m0 has priority.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       win
);

  logic last;

  // NOTE: every output of a combinational block gets a value before any branch, so no latch is inferred.
  always_comb begin
    valid = |req;
    win   = req[M_LDR];
    if (&req) win = ~last;
  end

  // NOTE: clocked state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) last <= 1'(M_LDR);
    else if (take && valid) last <= win;
  end

endmodule

// File: rtl/mem_arb.sv
// Two-master RAM arbiter: IDLE -> ACCESS (RAM_LAT cycles) -> DONE -> IDLE.
// All RAM and master-side outputs are registered; request fields are latched at grant.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int RAM_LAT = RAM_LAT_DEFAULT,
  parameter int AW      = 64,
  parameter int DW      = 64
) (
  input logic      clk,
  input logic      reset,
  mem_arb_if.slave bus
);

  state_t        state;
  logic [3:0]    cnt;
  logic [1:0]    gnt, done;
  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, rdata0, rdata1;

  logic          arb_valid, arb_win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arb2 u_arb (
    .clk  (clk),
    .reset(reset),
    .req  ({bus.m1_req, bus.m0_req}),
    .take (state == IDLE),
    .valid(arb_valid),
    .win  (arb_win)
  );

  always_comb begin
    sel_we    = bus.m0_we;
    sel_addr  = bus.m0_addr;
    sel_wdata = bus.m0_wdata;
    if (arb_win == 1'(M_LDR)) begin
      sel_we    = bus.m1_we;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
    end
  end

  // The ram_* registers double as the latched request: master inputs are ignored after grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state     <= ACCESS;
            cnt       <= 4'(RAM_LAT - 1);
            gnt       <= arb_win ? 2'b10 : 2'b01;
            ram_cs    <= 1'b1;
            ram_we    <= sel_we;
            ram_oe    <= ~sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (!ram_we) begin
              if (gnt[M_LDR]) rdata1 <= bus.ram_rdata;
              else            rdata0 <= bus.ram_rdata;
            end
            done      <= gnt;
            gnt       <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_gnt    = gnt[M_CPU];
  assign bus.m1_gnt    = gnt[M_LDR];
  assign bus.m0_done   = done[M_CPU];
  assign bus.m1_done   = done[M_LDR];
  assign bus.m0_rdata  = rdata0;
  assign bus.m1_rdata  = rdata1;
  assign bus.ram_cs    = ram_cs;
  assign bus.ram_we    = ram_we;
  assign bus.ram_oe    = ram_oe;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: two instances (RAM_LAT=1 and RAM_LAT=3) checked every cycle
// against a transaction-timeline model, plus directed scenarios with literal expectations.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, indexed [instance][master]
  logic [1:0]    req  [2];
  logic [1:0]    we_i [2];
  logic [AW-1:0] addr_i  [2][2];
  logic [DW-1:0] wdata_i [2][2];
  logic [DW-1:0] ram_rdata_i [2];

  // Observed outputs, indexed [instance]
  logic [1:0]    gnt_o [2], done_o [2];
  logic [DW-1:0] rdata_o [2][2];
  logic          cs_o [2], rwe_o [2], oe_o [2];
  logic [AW-1:0] raddr_o [2];
  logic [DW-1:0] rwdata_o [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    mem_arb #(.RAM_LAT(k == 0 ? 1 : 3), .AW(AW), .DW(DW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );

    assign bus.m0_req    = req[k][0];
    assign bus.m1_req    = req[k][1];
    assign bus.m0_we     = we_i[k][0];
    assign bus.m1_we     = we_i[k][1];
    assign bus.m0_addr   = addr_i[k][0];
    assign bus.m1_addr   = addr_i[k][1];
    assign bus.m0_wdata  = wdata_i[k][0];
    assign bus.m1_wdata  = wdata_i[k][1];
    assign bus.ram_rdata = ram_rdata_i[k];

    assign gnt_o[k]      = {bus.m1_gnt, bus.m0_gnt};
    assign done_o[k]     = {bus.m1_done, bus.m0_done};
    assign rdata_o[k][0] = bus.m0_rdata;
    assign rdata_o[k][1] = bus.m1_rdata;
    assign cs_o[k]       = bus.ram_cs;
    assign rwe_o[k]      = bus.ram_we;
    assign oe_o[k]       = bus.ram_oe;
    assign raddr_o[k]    = bus.ram_addr;
    assign rwdata_o[k]   = bus.ram_wdata;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Timeline model: a transaction starts at a grant edge; for the next lat edges
  // it is on the bus, then one done cycle, then one idle cycle before the next grant.
  bit            m_active [2];
  int            m_ph     [2];
  int            m_win    [2];
  bit            m_last   [2];
  bit            m_we     [2];
  logic [AW-1:0] m_addr   [2];
  logic [DW-1:0] m_wdata  [2];
  logic [DW-1:0] m_rdata  [2][2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_active[k]   = 1'b0;
        m_last[k]     = 1'b1;
        m_rdata[k][0] = '0;
        m_rdata[k][1] = '0;
      end else if (m_active[k]) begin
        m_ph[k]++;
        if (m_ph[k] == lat_of(k) && !m_we[k]) m_rdata[k][m_win[k]] = ram_rdata_i[k];
        if (m_ph[k] == lat_of(k) + 1) m_active[k] = 1'b0;
      end else if (req[k] != 2'b00) begin
        if (req[k] == 2'b11) m_win[k] = m_last[k] ? 0 : 1;
        else                 m_win[k] = req[k][1] ? 1 : 0;
        m_last[k]   = (m_win[k] == 1);
        m_active[k] = 1'b1;
        m_ph[k]     = 0;
        m_we[k]     = we_i[k][m_win[k]];
        m_addr[k]   = addr_i[k][m_win[k]];
        m_wdata[k]  = wdata_i[k][m_win[k]];
      end
    end
  end

  logic prev_cs [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin : compare
    bit         acc, dn;
    logic [1:0] e_gnt, e_done;
    string      p;
    for (int k = 0; k < 2; k++) begin
      p      = $sformatf("L%0d ", lat_of(k));
      acc    = m_active[k] && (m_ph[k] < lat_of(k));
      dn     = m_active[k] && (m_ph[k] == lat_of(k));
      e_gnt  = acc ? ((m_win[k] == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_done = dn  ? ((m_win[k] == 1) ? 2'b10 : 2'b01) : 2'b00;
      check({p, "gnt"},    64'(gnt_o[k]),  64'(e_gnt));
      check({p, "done"},   64'(done_o[k]), 64'(e_done));
      check({p, "ram_cs"}, 64'(cs_o[k]),   64'(acc));
      check({p, "ram_we"}, 64'(rwe_o[k]),  64'(acc && m_we[k]));
      check({p, "ram_oe"}, 64'(oe_o[k]),   64'(acc && !m_we[k]));
      check({p, "ram_addr"},  raddr_o[k],  acc ? m_addr[k]  : 64'd0);
      check({p, "ram_wdata"}, rwdata_o[k], acc ? m_wdata[k] : 64'd0);
      check({p, "m0_rdata"},  rdata_o[k][0], m_rdata[k][0]);
      check({p, "m1_rdata"},  rdata_o[k][1], m_rdata[k][1]);
      check({p, "one_gnt"},   64'($countones(gnt_o[k]) <= 1), 64'd1);
      check({p, "we_oe_excl"}, 64'(rwe_o[k] & oe_o[k]), 64'd0);
      if (done_o[k] != 2'b00) check({p, "done_after_cs"}, 64'(prev_cs[k] && !cs_o[k]), 64'd1);
      prev_cs[k] = cs_o[k];
    end
  end

  task automatic wait_done(input int k, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (done_o[k] == 2'b00 && waited < 40);
  endtask

  initial begin
    int w;
    for (int k = 0; k < 2; k++) begin
      req[k] = 2'b00;
      we_i[k] = 2'b00;
      ram_rdata_i[k] = '0;
      for (int m = 0; m < 2; m++) begin
        addr_i[k][m]  = '0;
        wdata_i[k][m] = '0;
      end
    end

    // Contention from reset on the RAM_LAT=1 instance: m0, m1, m0, m1, three cycles apart
    req[0] = 2'b11;
    repeat (3) @(negedge clk);
    check("reset_gnt", 64'(gnt_o[0]), 64'd0);
    check("reset_rdata", rdata_o[0][0], 64'd0);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_done(0, w);
      check($sformatf("contend_order%0d", n), 64'(done_o[0]), (n % 2 == 0) ? 64'd1 : 64'd2);
      if (n > 0) check($sformatf("contend_gap%0d", n), 64'(w), 64'd3);
    end
    req[0] = 2'b00;

    // Single read, RAM_LAT=1
    @(negedge clk);
    ram_rdata_i[0] = 64'hDEADBEEF;
    we_i[0][0]     = 1'b0;
    addr_i[0][0]   = 64'h100;
    req[0][0]      = 1'b1;
    @(negedge clk);
    req[0][0] = 1'b0;
    check("rd_gnt",  64'(gnt_o[0]), 64'd1);
    check("rd_cs",   64'(cs_o[0]), 64'd1);
    check("rd_oe",   64'(oe_o[0]), 64'd1);
    check("rd_addr", raddr_o[0], 64'h100);
    @(negedge clk);
    check("rd_done",   64'(done_o[0]), 64'd1);
    check("rd_cs_off", 64'(cs_o[0]), 64'd0);
    check("rd_data",   rdata_o[0][0], 64'hDEADBEEF);

    // Write by m1, RAM_LAT=3
    @(negedge clk);
    we_i[1][1]    = 1'b1;
    addr_i[1][1]  = 64'h2000;
    wdata_i[1][1] = 64'h55;
    req[1][1]     = 1'b1;
    @(negedge clk);
    req[1][1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_gnt%0d", i),   64'(gnt_o[1]), 64'd2);
      check($sformatf("wr_we%0d", i),    64'(rwe_o[1]), 64'd1);
      check($sformatf("wr_oe%0d", i),    64'(oe_o[1]), 64'd0);
      check($sformatf("wr_addr%0d", i),  raddr_o[1], 64'h2000);
      check($sformatf("wr_wdata%0d", i), rwdata_o[1], 64'h55);
      @(negedge clk);
    end
    check("wr_done",  64'(done_o[1]), 64'd2);
    check("wr_rdata", rdata_o[1][1], 64'd0);

    // Inputs change and req drops mid-access: latched address holds, done still issued
    @(negedge clk);
    ram_rdata_i[1] = 64'hCAFEF00D12345678;
    we_i[1][0]     = 1'b0;
    addr_i[1][0]   = 64'h100;
    req[1][0]      = 1'b1;
    @(negedge clk);
    addr_i[1][0] = 64'h300;
    req[1][0]    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_addr%0d", i), raddr_o[1], 64'h100);
      @(negedge clk);
    end
    check("hold_done",  64'(done_o[1]), 64'd1);
    check("hold_rdata", rdata_o[1][0], 64'hCAFEF00D12345678);

    // Reset during the 2nd of 3 access cycles, then contention must grant m0
    @(negedge clk);
    addr_i[1][0] = 64'h400;
    req[1][0]    = 1'b1;
    @(negedge clk);
    req[1][0] = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    req[1] = 2'b11;
    @(negedge clk);
    check("rst_gnt",  64'(gnt_o[1]), 64'd0);
    check("rst_cs",   64'(cs_o[1]), 64'd0);
    check("rst_addr", raddr_o[1], 64'd0);
    check("rst_done", 64'(done_o[1]), 64'd0);
    @(negedge clk);
    check("rst_no_done", 64'(done_o[1]), 64'd0);
    check("rst_rdata",   rdata_o[1][0], 64'd0);
    reset = 1'b1;
    wait_done(1, w);
    check("rst_first_m0", 64'(done_o[1]), 64'd1);
    req[1] = 2'b00;

    // Randomized traffic on both instances, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) begin
        req[k] = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
        we_i[k] = 2'($urandom_range(0, 3));
        ram_rdata_i[k] = {$urandom, $urandom};
        for (int m = 0; m < 2; m++) begin
          addr_i[k][m]  = {$urandom, $urandom};
          wdata_i[k][m] = {$urandom, $urandom};
        end
      end
    end

    @(negedge clk);
    reset = 1'b1;
    req[0] = 2'b00;
    req[1] = 2'b00;
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter RAM_LAT, default 1, SHALL set the number of cycles ram_cs is held per access (legal 1..15).
REQ-002 Parameter AW, default 64, SHALL set the address width.
REQ-003 Parameter DW, default 64, SHALL set the data width.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 mN_req  in  1  master N (N=0 CPU, N=1 loader) requests one RAM access.
REQ-007 mN_we  in  1  1=write, 0=read.
REQ-008 mN_addr  in  AW  access address.
REQ-009 mN_wdata  in  DW  write data.
REQ-010 mN_gnt  out  1  master N owns the RAM bus.
REQ-011 mN_done  out  1  one-cycle completion pulse.
REQ-012 mN_rdata  out  DW  read data.
REQ-013 ram_cs / ram_we / ram_oe  out  1 each  RAM enables.
REQ-014 ram_addr  out  AW  RAM address.
REQ-015 ram_wdata  out  DW  RAM write data.
REQ-016 ram_rdata  in  DW  RAM read data; tri-state merging is done outside this block.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-018 IDLE: with any mN_req high, the block SHALL select a winner, latch its we/addr/wdata, set winner gnt and go to ACCESS.
REQ-019 Arbitration SHALL be round-robin: the master not served last wins a tie; after reset, m0 has priority.
REQ-020 ACCESS: ram_cs=1, ram_we=latched we, ram_oe=~latched we, ram_addr/ram_wdata=latched values, all registered, for exactly RAM_LAT cycles, counted by a 4-bit down counter.
REQ-021 On the last ACCESS cycle of a read, ram_rdata SHALL be captured into the winner's mN_rdata.
REQ-022 DONE: all ram_* SHALL be 0, winner mN_done=1 for one cycle, gnt SHALL drop, and the FSM SHALL return to IDLE.
REQ-023 Latency: req high at IDLE edge t -> gnt and ram_cs from t+1, done at t+1+RAM_LAT; back-to-back transactions SHALL be separated by exactly one IDLE cycle.
REQ-024 mN_rdata SHALL hold its value until that master's next read completes; writes SHALL leave it unchanged.
REQ-025 Latched request fields SHALL be immune to master input changes after the grant; dropping req during ACCESS SHALL NOT abort the access.
REQ-026 A req still high in IDLE after done SHALL be treated as a new request.
REQ-027 At most one mN_gnt SHALL be high at any time; ram_we and ram_oe SHALL never both be 1.
REQ-028 With no req, the FSM SHALL remain in IDLE with all outputs 0 except mN_rdata.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, counter 0, round-robin pointer to m0-priority, and gnt/done/ram_* to 0, including mid-ACCESS; the aborted access SHALL report no done.
REQ-030 mN_rdata SHALL reset to 0.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, ACCESS, DONE), the master-index constants M_CPU=0 and M_LDR=1, and the RAM_LAT default.
REQ-032 Winner selection SHALL live in one sub-module, rr_arb2 (2-input round-robin with last-grant pointer), instantiated once.

Verification
REQ-033 Single read: RAM_LAT=1, m0 reads 0x100 with ram_rdata=0xDEADBEEF -> ram_cs/ram_oe high exactly 1 cycle with ram_addr=0x100; m0_done at t+2; m0_rdata=0xDEADBEEF.
REQ-034 Contention: m0 and m1 both req from reset -> m0 served first, then m1 after one IDLE cycle; alternation holds over 4 transactions with both reqs held.
REQ-035 Write with RAM_LAT=3: m1 writes 0x55 to 0x2000 -> ram_we high 3 cycles, ram_oe 0, ram_wdata=0x55, m1_done at t+4, m1_rdata unchanged.
REQ-036 Input change mid-access: m0 changes addr to 0x300 and drops req during ACCESS -> ram_addr stays at the latched 0x100, done still issued.
REQ-037 Reset mid-ACCESS: reset=0 in the 2nd of 3 ACCESS cycles -> next edge all ram_*/gnt 0, no done; first post-reset contention grants m0.
REQ-038 Continuous assertion check: at most one gnt, never ram_we&ram_oe, done only in the cycle after the last ram_cs cycle.
